// File: rtl/pmp_pkg.sv
// Shared types for the PMP check sequencer.
//   pmp_mode_e    : address-matching mode field A of pmpcfg
//   pmp_cfg_t     : one pmpcfg byte {L, rsvd, A, X, W, R}
//   access_type_e : request kind (read / write / execute / reserved)
//   seq_state_e   : sequencer FSM states
//   access_last() : last byte address touched by an access, 34-bit, no wrap
package pmp_pkg;

  localparam int PMP_ADDR_W = 34;

  typedef enum logic [1:0] {OFF = 2'b00, TOR = 2'b01, NA4 = 2'b10, NAPOT = 2'b11} pmp_mode_e;

  typedef struct packed {
    logic      l;
    logic [1:0] rsvd;
    pmp_mode_e a;
    logic      x;
    logic      w;
    logic      r;
  } pmp_cfg_t;

  typedef enum logic [1:0] {ACC_READ = 2'b00, ACC_WRITE = 2'b01, ACC_EXEC = 2'b10,
                            ACC_RSVD = 2'b11} access_type_e;

  typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, RESP = 2'b10} seq_state_e;

  // Size 11 is reserved and treated as a word access.
  function automatic logic [PMP_ADDR_W-1:0] access_last(input logic [31:0] addr,
                                                        input logic [1:0]  size);
    logic [PMP_ADDR_W-1:0] span;
    case (size)
      2'b00:   span = 34'd0;
      2'b01:   span = 34'd1;
      default: span = 34'd3;
    endcase
    return {2'b00, addr} + span;
  endfunction

endpackage

// File: rtl/pmp_entry_match.sv
// Combinational range check of one access against one PMP entry.
// Optional feature macro: PMP_TOR_EN (enables TOR matching; otherwise TOR acts as OFF).
// Ports:
//   cfg           in  8   pmpcfg byte of the entry
//   pmpaddr       in  32  pmpaddr of the entry (address bits [33:2])
//   prev_pmpaddr  in  32  pmpaddr of the previous entry (0 for entry 0), TOR lower bound
//   addr          in  32  access byte address
//   size          in  2   access size code
//   full_match    out 1   whole access lies inside the region
//   partial_match out 1   access overlaps the region but is not fully inside it
module pmp_entry_match
  import pmp_pkg::*;
(
  input  logic [7:0]  cfg,
  input  logic [31:0] pmpaddr,
  input  logic [31:0] prev_pmpaddr,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  output logic        full_match,
  output logic        partial_match
);

  pmp_cfg_t              c;
  logic [PMP_ADDR_W-1:0] lo;
  logic [PMP_ADDR_W-1:0] hi;
  logic [PMP_ADDR_W-1:0] base;
  logic [PMP_ADDR_W-1:0] top;
  logic [32:0]           napot_mask;
  logic                  region_en;
  logic                  overlap;
  logic                  cfg_unused;

  assign c          = pmp_cfg_t'(cfg);
  assign cfg_unused = ^{c.l, c.rsvd, c.x, c.w, c.r};

`ifndef PMP_TOR_EN
  logic prev_unused;
  assign prev_unused = ^prev_pmpaddr;
`endif

  // Region bounds are inclusive [base, top] in 34-bit byte addresses.
  always_comb begin
    lo         = {2'b00, addr};
    hi         = access_last(addr, size);
    // x ^ (x+1) sets the trailing ones plus the first zero: the NAPOT word mask.
    // All-ones pmpaddr yields a 33-bit mask that covers the whole 34-bit space.
    napot_mask = {1'b0, pmpaddr} ^ ({1'b0, pmpaddr} + 33'd1);
    base       = '0;
    top        = '0;
    region_en  = 1'b0;
    case (c.a)
      NA4: begin
        base      = {pmpaddr, 2'b00};
        top       = {pmpaddr, 2'b11};
        region_en = 1'b1;
      end
      NAPOT: begin
        base      = {pmpaddr & ~napot_mask[31:0], 2'b00};
        top       = {pmpaddr | napot_mask[31:0], 2'b11};
        region_en = 1'b1;
      end
`ifdef PMP_TOR_EN
      TOR: begin
        base      = {prev_pmpaddr, 2'b00};
        top       = {pmpaddr, 2'b00} - 34'd1;
        region_en = (prev_pmpaddr < pmpaddr);
      end
`endif
      default: ;
    endcase
  end

  assign full_match    = region_en && (lo >= base) && (hi <= top);
  assign overlap       = region_en && (lo <= top) && (hi >= base);
  assign partial_match = overlap && !full_match;

endmodule

// File: rtl/pmp_check_sequencer.sv
// Iterative PMP access checker: scans one entry per clock through a single
// shared pmp_entry_match instance, lowest index wins, and returns allow/deny
// plus the deciding entry.
// Optional feature macro: PMP_TOR_EN (TOR matching and previous-entry address mux).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_addr/size/type/priv_m  access attributes, latched on accept
//   pmpcfg, pmpaddr            flattened CSR entries, must be stable while cfg_busy
//   cfg_busy                   scan or response pending
//   resp_valid/resp_ready      response handshake
//   resp_allow/hit/idx         decision, match flag, deciding entry (0 if no hit)
module pmp_check_sequencer
  import pmp_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_addr,
  input  logic [1:0]               req_size,
  input  logic [1:0]               req_type,
  input  logic                     req_priv_m,
  input  logic [8*NUM_ENTRIES-1:0]  pmpcfg,
  input  logic [32*NUM_ENTRIES-1:0] pmpaddr,
  output logic                     cfg_busy,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_allow,
  output logic                     resp_hit,
  output logic [IDX_W-1:0]         resp_idx
);

  seq_state_e       state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             load_resp;
  logic             accept;
  logic             last;

  logic [31:0]      a_addr;
  logic [1:0]       a_size;
  logic [1:0]       a_type;
  logic             a_priv;

  pmp_cfg_t         cur_cfg;
  logic [31:0]      cur_addr;
  logic [31:0]      prev_addr;
  logic             full_match;
  logic             partial_match;
  logic             decided;
  logic             cfg_unused;

  function automatic logic decide(input logic hit, input logic partial, input pmp_cfg_t c,
                                  input access_type_e t, input logic priv_m);
    if (t == ACC_RSVD) return 1'b0;
    if (!hit)          return priv_m;
    if (partial)       return 1'b0;
    if (!c.l && priv_m) return 1'b1;
    case (t)
      ACC_READ:  return c.r;
      ACC_WRITE: return c.w;
      default:   return c.x;
    endcase
  endfunction

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign cfg_busy   = (state != IDLE);
  assign accept     = req_valid && req_ready;
  assign last       = (idx == IDX_W'(NUM_ENTRIES - 1));

  // Entry select mux feeding the shared match datapath.
  assign cur_cfg    = pmp_cfg_t'(pmpcfg[8*idx +: 8]);
  assign cur_addr   = pmpaddr[32*idx +: 32];
  assign cfg_unused = ^cur_cfg.rsvd;

`ifdef PMP_TOR_EN
  logic [IDX_W-1:0] prev_idx;
  assign prev_idx  = idx - 1'b1;
  assign prev_addr = (idx == '0) ? 32'd0 : pmpaddr[32*prev_idx +: 32];
`else
  assign prev_addr = 32'd0;
`endif

  pmp_entry_match u_match (
    .cfg          (cur_cfg),
    .pmpaddr      (cur_addr),
    .prev_pmpaddr (prev_addr),
    .addr         (a_addr),
    .size         (a_size),
    .full_match   (full_match),
    .partial_match(partial_match)
  );

  assign decided = full_match || partial_match;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    load_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SCAN;
          idx_n   = '0;
        end
      end
      SCAN: begin
        if (decided || last) begin
          state_n   = RESP;
          load_resp = 1'b1;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      resp_allow <= 1'b0;
      resp_hit   <= 1'b0;
      resp_idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (load_resp) begin
        resp_allow <= decide(decided, partial_match, cur_cfg, access_type_e'(a_type), a_priv);
        resp_hit   <= decided;
        resp_idx   <= decided ? idx : '0;
      end
    end
  end

  // Request attributes are pure data; captured only on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_addr <= req_addr;
      a_size <= req_size;
      a_type <= req_type;
      a_priv <= req_priv_m;
    end
  end

endmodule

// File: tb/tb_pmp_check_sequencer.sv
module tb_pmp_check_sequencer;

  localparam int N = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic [1:0]      req_size;
  logic [1:0]      req_type;
  logic            req_priv_m;
  logic [8*N-1:0]  pmpcfg;
  logic [32*N-1:0] pmpaddr;
  logic            cfg_busy;
  logic            resp_valid;
  logic            resp_ready;
  logic            resp_allow;
  logic            resp_hit;
  logic [3:0]      resp_idx;

  logic [7:0]      cfg_a  [N];
  logic [31:0]     addr_a [N];

  int checks = 0;
  int errors = 0;

  pmp_check_sequencer #(.NUM_ENTRIES(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_type(req_type), .req_priv_m(req_priv_m),
    .pmpcfg(pmpcfg), .pmpaddr(pmpaddr), .cfg_busy(cfg_busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_allow(resp_allow), .resp_hit(resp_hit), .resp_idx(resp_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: byte-range arithmetic over the entry table.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] ty,
                                input logic pm, output logic al, output logic h,
                                output int ix, output int lat);
    longint lo, hi, base, top, pa, pv;
    int     nb, t;
    logic   ok, found, full;
    logic [7:0] c;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    lo = longint'(a);
    hi = lo + nb - 1;
    found = 1'b0; h = 1'b0; ix = 0; al = pm;
    base = 0; top = 0;
    for (int i = 0; i < N; i++) begin
      if (!found) begin
        c  = cfg_a[i];
        pa = longint'(addr_a[i]);
        ok = 1'b0;
        if (c[4:3] == 2'b10) begin
          base = pa * 4; top = base + 3; ok = 1'b1;
        end else if (c[4:3] == 2'b11) begin
          t = 0;
          while (t < 32 && pa[t]) t++;
          base = (pa >> (t + 1)) << (t + 3);
          top  = base + (longint'(1) << (t + 3)) - 1;
          ok   = 1'b1;
        end
`ifdef PMP_TOR_EN
        else if (c[4:3] == 2'b01) begin
          pv   = (i == 0) ? 0 : longint'(addr_a[i-1]) * 4;
          base = pv; top = pa * 4 - 1; ok = (pv < pa * 4);
        end
`endif
        if (ok && lo <= top && hi >= base) begin
          found = 1'b1; h = 1'b1; ix = i;
          full  = (lo >= base) && (hi <= top);
          if (!full)                 al = 1'b0;
          else if (!c[7] && pm)      al = 1'b1;
          else                       al = c[ty];
        end
      end
    end
    if (ty == 2'b11) al = 1'b0;
    lat = found ? ix + 2 : N + 1;
  endfunction

  // Compare process: every cycle a response is pending, check against the model.
  logic pend = 1'b0, seen = 1'b0;
  logic e_al, e_h;
  int   e_ix, e_lat, edges = 0;

  always @(posedge clk) begin
    if (!rst_n) pend = 1'b0;
    else begin
      if (pend && seen && resp_valid && resp_ready) pend = 1'b0;
      if (req_valid && req_ready) begin
        model(req_addr, req_size, req_type, req_priv_m, e_al, e_h, e_ix, e_lat);
        pend = 1'b1; seen = 1'b0; edges = 1;
      end else if (pend) edges++;
    end
    #1;
    if (pend && resp_valid === 1'b1) begin
      if (!seen) begin
        seen = 1'b1;
        chk("mon_latency", edges, e_lat);
      end
      chk("mon_allow", resp_allow, e_al);
      chk("mon_hit", resp_hit, e_h);
      chk("mon_idx", resp_idx, e_ix);
      chk("mon_busy", cfg_busy, 1'b1);
      chk("mon_req_ready", req_ready, 1'b0);
    end else if (pend && !seen && edges > 40) begin
      chk("mon_timeout", 1'b0, 1'b1);
      pend = 1'b0;
    end else if (!pend && rst_n && resp_valid === 1'b1) begin
      chk("mon_spurious_resp", resp_valid, 1'b0);
    end
  end

  task automatic apply_cfg();
    for (int i = 0; i < N; i++) begin
      pmpcfg[8*i +: 8]   = cfg_a[i];
      pmpaddr[32*i +: 32] = addr_a[i];
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin
      cfg_a[i] = 8'h00; addr_a[i] = 32'h0;
    end
  endtask

  task automatic send(input string nm, input logic [31:0] a, input logic [1:0] sz,
                      input logic [1:0] ty, input logic pm, input int hold,
                      input logic xa, input logic xh, input int xi, input int xl);
    int n;
    logic ha, hh;
    logic [3:0] hx;
    @(negedge clk);
    apply_cfg();
    req_addr = a; req_size = sz; req_type = ty; req_priv_m = pm; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 40) begin @(negedge clk); n++; end
    if (!resp_valid) begin
      chk({nm, "_timeout"}, 1'b0, 1'b1);
    end else begin
      chk({nm, "_latency"}, n + 1, xl);
      chk({nm, "_allow"}, resp_allow, xa);
      chk({nm, "_hit"}, resp_hit, xh);
      chk({nm, "_idx"}, resp_idx, xi);
      ha = resp_allow; hh = resp_hit; hx = resp_idx;
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        chk({nm, "_hold_valid"}, resp_valid, 1'b1);
        chk({nm, "_hold_req_ready"}, req_ready, 1'b0);
        chk({nm, "_hold_busy"}, cfg_busy, 1'b1);
        chk({nm, "_hold_out"}, {resp_allow, resp_hit, resp_idx}, {ha, hh, hx});
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({nm, "_done_ready"}, req_ready, 1'b1);
    chk({nm, "_done_valid"}, resp_valid, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_size = '0; req_type = '0; req_priv_m = 1'b0;
    clear_cfg();
    apply_cfg();
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_outs", {resp_allow, resp_hit, resp_idx}, 6'd0);
    chk("rst_busy", cfg_busy, 1'b0);
    rst_n = 1'b1;

    // NAPOT RW- over 0x0-0xFFF
    cfg_a[0] = 8'h1B; addr_a[0] = 32'h000001FF;
    send("napot_read",     32'h100, 2'b10, 2'b00, 1'b0, 0, 1'b1, 1'b1, 0, 2);
    send("napot_straddle", 32'hFFE, 2'b10, 2'b01, 1'b0, 0, 1'b0, 1'b1, 0, 2);
    send("napot_top_word", 32'hFFC, 2'b10, 2'b00, 1'b0, 0, 1'b1, 1'b1, 0, 2);
    send("napot_exec",     32'h200, 2'b10, 2'b10, 1'b0, 0, 1'b0, 1'b1, 0, 2);
    send("napot_above",    32'h1000, 2'b00, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0, 17);

    // NA4 R-only at entry 3
    clear_cfg();
    cfg_a[3] = 8'h11; addr_a[3] = 32'h00000400;
    send("na4_exec",  32'h1000, 2'b10, 2'b10, 1'b0, 0, 1'b0, 1'b1, 3, 5);
    send("na4_read",  32'h1002, 2'b01, 2'b00, 1'b0, 0, 1'b1, 1'b1, 3, 5);

    // All entries off
    clear_cfg();
    send("off_m", 32'h80000000, 2'b10, 2'b00, 1'b1, 0, 1'b1, 1'b0, 0, 17);
    send("off_s", 32'h80000000, 2'b10, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0, 17);
    send("off_m_rsvd", 32'h80000000, 2'b10, 2'b11, 1'b1, 0, 1'b0, 1'b0, 0, 17);

    // Lock bit
    cfg_a[0] = 8'h99; addr_a[0] = 32'h000001FF;
    send("locked_m_write", 32'h10, 2'b10, 2'b01, 1'b1, 0, 1'b0, 1'b1, 0, 2);
    cfg_a[0] = 8'h19;
    send("unlocked_m_write", 32'h10, 2'b10, 2'b01, 1'b1, 0, 1'b1, 1'b1, 0, 2);
    send("unlocked_m_rsvd",  32'h10, 2'b10, 2'b11, 1'b1, 0, 1'b0, 1'b1, 0, 2);

    // Top of address space: no 32-bit wrap
    clear_cfg();
    cfg_a[5] = 8'h19; addr_a[5] = 32'hFFFFFFFF;
    send("whole_space", 32'hFFFFFFFE, 2'b10, 2'b00, 1'b0, 0, 1'b1, 1'b1, 5, 7);
    cfg_a[2] = 8'h11; addr_a[2] = 32'h3FFFFFFF;
    send("na4_wrap_partial", 32'hFFFFFFFE, 2'b10, 2'b00, 1'b0, 0, 1'b0, 1'b1, 2, 4);

    // Backpressure hold
    clear_cfg();
    cfg_a[0] = 8'h1B; addr_a[0] = 32'h000001FF;
    send("hold", 32'h100, 2'b10, 2'b00, 1'b0, 5, 1'b1, 1'b1, 0, 2);

    // TOR entry 1 over [0x1000, 0x2000)
    clear_cfg();
    addr_a[0] = 32'h400; cfg_a[1] = 8'h09; addr_a[1] = 32'h800;
`ifdef PMP_TOR_EN
    send("tor_read", 32'h1800, 2'b10, 2'b00, 1'b0, 0, 1'b1, 1'b1, 1, 3);
`else
    send("tor_as_off", 32'h1800, 2'b10, 2'b00, 1'b0, 0, 1'b0, 1'b0, 0, 17);
`endif

    // Reset during scan
    clear_cfg();
    @(negedge clk);
    apply_cfg();
    req_addr = 32'h80000000; req_size = 2'b10; req_type = 2'b00; req_priv_m = 1'b1;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scan_busy", cfg_busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_valid", resp_valid, 1'b0);
    chk("midrst_busy", cfg_busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 1'b1);
    repeat (20) @(negedge clk);
    chk("midrst_no_resp", resp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
